// File: rtl/serial_word_receiver.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_receiver
// Purpose  : Receive side of the tick-paced serial link. Samples SI once per
//            tick, recovers framed characters (start 0, data MSB first,
//            stop 1) and packs NBYTES good characters into one word, first
//            character in the MSBs.
// Ports    : clk        - system clock (100 MHz)
//            rst_n      - asynchronous active-low reset
//            tick       - one-cycle bit-period strobe
//            SI         - serial input, idles high
//            pdata      - last good character
//            byte_valid - one-cycle pulse when pdata updates
//            word_out   - last completed word
//            word_valid - one-cycle pulse when word_out updates
//            frame_err  - one-cycle pulse on a bad stop bit
//            busy       - high while a frame is in progress
// Revision : 1.0 - initial release
// ============================================================================
module serial_word_receiver #(
   parameter int WIDTH  = 8,
   parameter int NBYTES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    tick,
   input  logic                    SI,
   output logic [WIDTH-1:0]        pdata,
   output logic                    byte_valid,
   output logic [WIDTH*NBYTES-1:0] word_out,
   output logic                    word_valid,
   output logic                    frame_err,
   output logic                    busy
);

   localparam int c_CNT_W  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int c_IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int c_WORD_W = WIDTH * NBYTES;
   localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WIDTH - 1);
   localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NBYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_STOP = 2'd2
   } state_t;

   state_t                r_state,      w_state_next;
   logic [WIDTH-1:0]      r_shreg,      w_shreg_next;
   logic [c_CNT_W-1:0]    r_bit_cnt,    w_bit_cnt_next;
   logic [c_IDX_W-1:0]    r_byte_idx,   w_byte_idx_next;
   logic [c_WORD_W-1:0]   r_wbuf,       w_wbuf_next;
   logic [c_WORD_W-1:0]   w_wbuf_ins;
   logic [WIDTH-1:0]      r_pdata,      w_pdata_next;
   logic [c_WORD_W-1:0]   r_word_out,   w_word_out_next;
   logic                  r_byte_valid, w_byte_valid_next;
   logic                  r_word_valid, w_word_valid_next;
   logic                  r_frame_err,  w_frame_err_next;
   logic                  r_busy,       w_busy_next;

   assign pdata      = r_pdata;
   assign byte_valid = r_byte_valid;
   assign word_out   = r_word_out;
   assign word_valid = r_word_valid;
   assign frame_err  = r_frame_err;
   assign busy       = r_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_shreg      <= '0;
         r_bit_cnt    <= '0;
         r_byte_idx   <= '0;
         r_wbuf       <= '0;
         r_pdata      <= '0;
         r_word_out   <= '0;
         r_byte_valid <= 1'b0;
         r_word_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_shreg      <= w_shreg_next;
         r_bit_cnt    <= w_bit_cnt_next;
         r_byte_idx   <= w_byte_idx_next;
         r_wbuf       <= w_wbuf_next;
         r_pdata      <= w_pdata_next;
         r_word_out   <= w_word_out_next;
         r_byte_valid <= w_byte_valid_next;
         r_word_valid <= w_word_valid_next;
         r_frame_err  <= w_frame_err_next;
         r_busy       <= w_busy_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_shreg_next      = r_shreg;
      w_bit_cnt_next    = r_bit_cnt;
      w_byte_idx_next   = r_byte_idx;
      w_wbuf_next       = r_wbuf;
      w_pdata_next      = r_pdata;
      w_word_out_next   = r_word_out;
      w_byte_valid_next = 1'b0;
      w_word_valid_next = 1'b0;
      w_frame_err_next  = 1'b0;

      // Word buffer with the current character dropped into its slot, so the
      // last character of a word reaches word_out in the same cycle.
      w_wbuf_ins = r_wbuf;
      for (int s = 0; s < NBYTES; s++) begin
         if (r_byte_idx == c_IDX_W'(s)) begin
            w_wbuf_ins[c_WORD_W-1-s*WIDTH -: WIDTH] = r_shreg;
         end
      end

      if (tick) begin
         case (r_state)
            S_IDLE: begin
               // Start bit is taken on a single sample; a glitch is only
               // rejected later by the stop-bit check.
               if (!SI) begin
                  w_state_next   = S_DATA;
                  w_bit_cnt_next = '0;
               end
            end
            S_DATA: begin
               w_shreg_next   = {r_shreg[WIDTH-2:0], SI};
               w_bit_cnt_next = r_bit_cnt + 1'b1;
               if (r_bit_cnt == c_LAST_BIT) begin
                  w_state_next = S_STOP;
               end
            end
            S_STOP: begin
               w_state_next = S_IDLE;
               if (SI) begin
                  w_pdata_next      = r_shreg;
                  w_byte_valid_next = 1'b1;
                  w_wbuf_next       = w_wbuf_ins;
                  if (r_byte_idx == c_LAST_IDX) begin
                     w_word_out_next   = w_wbuf_ins;
                     w_word_valid_next = 1'b1;
                     w_byte_idx_next   = '0;
                  end else begin
                     w_byte_idx_next = r_byte_idx + 1'b1;
                  end
               end else begin
                  // Bad stop bit: the partial word is dropped.
                  w_frame_err_next = 1'b1;
                  w_byte_idx_next  = '0;
               end
            end
            default: begin
               w_state_next = S_IDLE;
            end
         endcase
      end

      w_busy_next = (w_state_next != S_IDLE);
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_word_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_word_receiver
// Purpose  : Self-checking bench for serial_word_receiver using a table of
//            framed characters with expected outputs plus directed sequences
//            for idle hold, continuous tick, mid-frame reset and loopback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_word_receiver;

   localparam int WIDTH  = 8;
   localparam int NBYTES = 4;

   logic                    clk   = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    tick  = 1'b0;
   logic                    SI    = 1'b1;
   logic [WIDTH-1:0]        pdata;
   logic                    byte_valid;
   logic [WIDTH*NBYTES-1:0] word_out;
   logic                    word_valid;
   logic                    frame_err;
   logic                    busy;

   int errors = 0;
   int checks = 0;
   int n_bv   = 0;
   int n_wv   = 0;
   int n_fe   = 0;

   serial_word_receiver #(.WIDTH(WIDTH), .NBYTES(NBYTES)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .SI         (SI),
      .pdata      (pdata),
      .byte_valid (byte_valid),
      .word_out   (word_out),
      .word_valid (word_valid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Pulse counters; each pulse spans one cycle so one negedge sees it once.
   always @(negedge clk) begin
      if (byte_valid) n_bv++;
      if (word_valid) n_wv++;
      if (frame_err)  n_fe++;
   end

   typedef struct {
      logic [7:0]  data;
      logic        stop;
      logic [7:0]  exp_pdata;
      logic        exp_bv;
      logic        exp_wv;
      logic        exp_fe;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Hold SI for gap idle cycles, then one tick cycle; returns at the negedge
   // after the tick was sampled, where registered outputs show its effect.
   task automatic send_bit(input logic b, input int gap);
      SI   = b;
      tick = 1'b0;
      repeat (gap) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
      send_bit(1'b0, gap);
      for (int i = WIDTH - 1; i >= 0; i--) send_bit(d[i], gap);
      send_bit(stop, gap);
   endtask

   task automatic check_frame(input string tag, input vec_t v);
      check({tag, ".pdata"},      {24'h0, pdata}, {24'h0, v.exp_pdata});
      check({tag, ".byte_valid"}, {31'h0, byte_valid}, {31'h0, v.exp_bv});
      check({tag, ".word_valid"}, {31'h0, word_valid}, {31'h0, v.exp_wv});
      check({tag, ".frame_err"},  {31'h0, frame_err},  {31'h0, v.exp_fe});
      check({tag, ".word_out"},   word_out, v.exp_word);
      check({tag, ".busy"},       {31'h0, busy}, 32'h0);
   endtask

   initial begin
      int bv0, wv0, fe0, bad;
      logic [31:0] w;
      vec_t v;

      vecs[0] = '{8'hDE, 1'b1, 8'hDE, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
      vecs[1] = '{8'hAD, 1'b1, 8'hAD, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
      vecs[2] = '{8'hBE, 1'b1, 8'hBE, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
      vecs[3] = '{8'hEF, 1'b1, 8'hEF, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF};
      vecs[4] = '{8'h12, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF};
      vecs[5] = '{8'h34, 1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
      vecs[6] = '{8'h56, 1'b1, 8'h56, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF};
      vecs[7] = '{8'h78, 1'b1, 8'h78, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF};
      vecs[8] = '{8'h9A, 1'b1, 8'h9A, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF};
      vecs[9] = '{8'hBC, 1'b1, 8'hBC, 1'b1, 1'b1, 1'b0, 32'h5678_9ABC};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst.pdata",      {24'h0, pdata}, 32'h0);
      check("rst.word_out",   word_out, 32'h0);
      check("rst.pulses",     {29'h0, byte_valid, word_valid, frame_err}, 32'h0);
      check("rst.busy",       {31'h0, busy}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single frame 0xA5 with a slow tick (every 1000 cycles)
      bv0 = n_bv; wv0 = n_wv;
      send_bit(1'b0, 999);
      check("a5.busy_rise", {31'h0, busy}, 32'h1);
      for (int i = WIDTH - 1; i >= 0; i--) send_bit(w_bit(8'hA5, i), 999);
      send_bit(1'b1, 999);
      v = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 32'h0};
      check_frame("a5", v);
      @(negedge clk); #1;
      check("a5.bv_count", n_bv - bv0, 32'd1);
      check("a5.wv_count", n_wv - wv0, 32'd0);

      // Re-align byte_idx to 0 for the word tests
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Table: DEADBEEF word, then an errored frame and 56789ABC
      bv0 = n_bv; wv0 = n_wv; fe0 = n_fe;
      for (int k = 0; k < 10; k++) begin
         send_frame(vecs[k].data, vecs[k].stop, k % 3);
         check_frame($sformatf("vec%0d", k), vecs[k]);
      end
      @(negedge clk); #1;
      check("tbl.bv_count", n_bv - bv0, 32'd9);
      check("tbl.wv_count", n_wv - wv0, 32'd2);
      check("tbl.fe_count", n_fe - fe0, 32'd1);

      // SI low with no tick must not start a frame
      SI = 1'b0;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (busy !== 1'b0) bad++;
      end
      check("idle_hold.busy_cycles", bad, 32'd0);

      // Continuous tick: one bit per clk
      send_frame(8'h3C, 1'b1, 0);
      v = '{8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 32'h5678_9ABC};
      check_frame("fast3c", v);

      // Reset after 4 data bits of 0xFF
      send_bit(1'b0, 2);
      repeat (4) send_bit(1'b1, 2);
      rst_n = 1'b0;
      #1;
      check("midrst.pdata",    {24'h0, pdata}, 32'h0);
      check("midrst.word_out", word_out, 32'h0);
      check("midrst.busy",     {31'h0, busy}, 32'h0);
      check("midrst.pulses",   {29'h0, byte_valid, word_valid, frame_err}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) send_bit(1'b1, 1);
      send_frame(8'h81, 1'b1, 1);
      v = '{8'h81, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 32'h0};
      check_frame("post81", v);
      send_frame(8'h00, 1'b1, 1);
      send_frame(8'hFF, 1'b1, 1);
      send_frame(8'h42, 1'b1, 1);
      v = '{8'h42, 1'b1, 8'h42, 1'b1, 1'b1, 1'b0, 32'h8100_FF42};
      check_frame("post42", v);

      // Loopback with a bench-side transmitter of random words
      fe0 = n_fe;
      for (int k = 0; k < 8; k++) begin
         w = $urandom;
         for (int b = 0; b < NBYTES; b++) begin
            send_frame(w[31-8*b -: 8], 1'b1, int'($urandom_range(0, 3)));
         end
         check($sformatf("loop%0d.word_valid", k), {31'h0, word_valid}, 32'h1);
         check($sformatf("loop%0d.word_out", k), word_out, w);
      end
      @(negedge clk); #1;
      check("loop.fe_count", n_fe - fe0, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   function automatic logic w_bit(input logic [7:0] d, input int i);
      return d[i];
   endfunction

endmodule
`default_nettype wire

// File: doc/serial_word_receiver.md
# serial_word_receiver

Receive side of the tick-paced serial link that carries sine-table samples out of the ROM shifter. Samples a single serial line once per `tick`, recovers framed WIDTH-bit characters (start bit, data MSB first, stop bit), and packs NBYTES consecutive good characters into one parallel word, giving back the 32-bit bus image the transmitter consumed. It sits at the far end of the serial wire and feeds the DAC or capture logic.

## Interface
- `WIDTH`, default 8: data bits per character.
- `NBYTES`, default 4: characters per assembled word; word width is WIDTH*NBYTES (32 by default).
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  bit-period strobe, one `clk` cycle wide; `SI` is sampled only in cycles with `tick`=1.
- `SI`  in  1  serial input; idles high.
- `pdata`  out  WIDTH  last good character.
- `byte_valid`  out  1  one-cycle pulse when `pdata` is updated.
- `word_out`  out  WIDTH*NBYTES  last completed word; first received character in the MSBs.
- `word_valid`  out  1  one-cycle pulse when `word_out` is updated.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Frame format: start bit 0, WIDTH data bits MSB first, stop bit 1. Each bit lasts one tick period.
- FSM states: IDLE, DATA, STOP. Transitions happen only on `tick` cycles. Without `tick`, state, counters and shift register hold.
- IDLE: on `tick` with `SI`=0, go to DATA and clear `bit_cnt`. On `tick` with `SI`=1, stay in IDLE.
- DATA: on each `tick`, `shreg <= {shreg[WIDTH-2:0], SI}` and `bit_cnt` increments. After the tick that samples bit WIDTH-1, go to STOP.
- STOP, `tick` with `SI`=1:
  - `pdata <= shreg` and pulse `byte_valid`.
  - Write the character into slot `byte_idx` of the word buffer (slot 0 is bits [WIDTH*NBYTES-1 -: WIDTH]) and increment `byte_idx`.
  - If the character completes slot NBYTES-1, load `word_out` from the full buffer (including this character), pulse `word_valid`, and set `byte_idx` to 0.
  - Go to IDLE.
- STOP, `tick` with `SI`=0: pulse `frame_err`, discard the character, set `byte_idx` to 0 (the partial word is dropped), and go to IDLE. `pdata` and `word_out` are unchanged.
- `bit_cnt` width is clog2(WIDTH). `byte_idx` width is clog2(NBYTES), minimum 1, and it wraps at NBYTES, not at a power of 2.
- The start bit is not re-checked. A glitch that reads as a start bit is accepted and is caught only by the stop check.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE; `shreg`, `bit_cnt`, `byte_idx`, `pdata` and `word_out` all 0; `byte_valid`, `word_valid`, `frame_err` and `busy` all 0.
- Reset asserted mid-frame aborts the frame immediately. After release, reception restarts only on a new start bit.
- All outputs are registered. `byte_valid`, `word_valid` and `frame_err` are high for exactly the one cycle after the `clk` edge at which the stop-bit `tick` was sampled.
- `pdata` and `word_out` change in the same cycle as their valid pulses and hold until the next update.
- `word_valid` coincides with the `byte_valid` of the last character of the word.
- Frame length is WIDTH+2 ticks. Back-to-back frames with no idle gap are legal: the tick after the stop bit may be the next start bit.
- `tick` held high continuously is legal and means one bit per `clk`.
- `busy` rises the cycle after the start-bit tick and falls the cycle after the stop-bit tick.

## Test plan
- Reset, then send frame 0xA5 with `tick` every 1000 cycles -> `pdata`=0xA5, one `byte_valid` pulse, no `word_valid`, `frame_err`=0.
- Send 0xDE, 0xAD, 0xBE, 0xEF back-to-back -> four `byte_valid` pulses; `word_valid` on the 4th with `word_out`=0xDEADBEEF; `byte_idx` returns to 0.
- Send 0x12, then 0x34 with stop bit 0, then 0x56, 0x78, 0x9A, 0xBC -> `frame_err` pulse on 0x34; `pdata` stays 0x12 after the error; the next `word_out`=0x56789ABC.
- Drive `SI`=0 for 50 cycles with no `tick` in IDLE -> state stays IDLE, `busy`=0; with `tick`=1 every cycle, frame 0x3C is received correctly.
- Pull `rst_n` low after 4 data bits of 0xFF -> all outputs 0 immediately; after release, frame 0x81 is received cleanly with `byte_idx` starting at 0.
- Loopback against the ROM shifter (SO->SI) with random 32-bit `Data_bus` values -> every `word_out` equals the transmitted word; `frame_err` is never asserted.
